// File: rtl/mult_pipe_rnd.sv
// Pipelined signed multiplier with selectable rounding, output narrowing and valid tracking.
// Define MULT_PIPE_SAT_EN to clamp overflowing results and drive ovf_o; otherwise results wrap.
module mult_pipe_rnd #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int O_WIDTH     = 16,
    parameter int DROP_MSB    = 1,
    parameter int PIPE_STAGES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [A_WIDTH-1:0] a_i,
    input  logic [B_WIDTH-1:0] b_i,
    input  logic [1:0]         rnd_mode_i,
    output logic [O_WIDTH-1:0] mult_o,
    output logic               valid_o,
    output logic               ovf_o
);

    localparam int N  = A_WIDTH + B_WIDTH;
    localparam int D  = N - DROP_MSB - O_WIDTH;
    // rounded result: kept window plus dropped sign bits plus one guard bit
    localparam int RW = N + 1 - D;

    logic signed [A_WIDTH-1:0] a_s1;
    logic signed [B_WIDTH-1:0] b_s1;
    logic [1:0]                mode_s1;
    logic                      valid_s1;

    logic signed [N-1:0]       prod_s2;
    logic [1:0]                mode_s2;
    logic                      valid_s2;

    logic signed [N-1:0]       prod_d  [PIPE_STAGES];
    logic [1:0]                mode_d  [PIPE_STAGES];
    logic                      valid_d [PIPE_STAGES];

    logic signed [N-1:0]       p_last;
    logic [1:0]                m_last;
    logic [RW-1:0]             r_full;
    logic [O_WIDTH-1:0]        result;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_s1     <= '0;
            b_s1     <= '0;
            mode_s1  <= '0;
            valid_s1 <= 1'b0;
        end else if (en_i) begin
            a_s1     <= a_i;
            b_s1     <= b_i;
            mode_s1  <= rnd_mode_i;
            valid_s1 <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_s2  <= '0;
            mode_s2  <= '0;
            valid_s2 <= 1'b0;
        end else if (en_i) begin
            prod_s2  <= N'(a_s1) * N'(b_s1);
            mode_s2  <= mode_s1;
            valid_s2 <= valid_s1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                prod_d[i]  <= '0;
                mode_d[i]  <= '0;
                valid_d[i] <= 1'b0;
            end
        end else if (en_i) begin
            prod_d[0]  <= prod_s2;
            mode_d[0]  <= mode_s2;
            valid_d[0] <= valid_s2;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                prod_d[i]  <= prod_d[i-1];
                mode_d[i]  <= mode_d[i-1];
                valid_d[i] <= valid_d[i-1];
            end
        end
    end

    assign p_last = prod_d[PIPE_STAGES-1];
    assign m_last = mode_d[PIPE_STAGES-1];

    generate
        if (D > 0) begin : g_round
            localparam logic [D-1:0] HALF = D'(1) << (D - 1);
            logic       tie;
            logic       round_add;
            logic [N:0] sum;

            assign tie = (p_last[D-1:0] == HALF);
            // convergent skips the half-add only on an exact tie whose kept LSB is already even
            assign round_add = (m_last == 2'd1) ||
                               ((m_last == 2'd2) && !(tie && !p_last[D]));
            assign sum    = {p_last[N-1], p_last} +
                            (round_add ? {{(N + 1 - D){1'b0}}, HALF} : '0);
            assign r_full = sum[N:D];
        end else begin : g_exact
            logic mode_unused;
            assign mode_unused = ^m_last;
            assign r_full      = {p_last[N-1], p_last};
        end
    endgenerate

`ifdef MULT_PIPE_SAT_EN
    localparam logic [O_WIDTH-1:0] MAX_POS = {1'b0, {(O_WIDTH - 1){1'b1}}};
    localparam logic [O_WIDTH-1:0] MIN_NEG = {1'b1, {(O_WIDTH - 1){1'b0}}};

    logic [RW-O_WIDTH:0] top_bits;
    logic                ovf_c;

    // result fits only if every bit from the output sign upward agrees
    assign top_bits = r_full[RW-1:O_WIDTH-1];
    assign ovf_c    = !((&top_bits) || !(|top_bits));
    assign result   = ovf_c ? (r_full[RW-1] ? MIN_NEG : MAX_POS) : r_full[O_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
        end else if (en_i) begin
            ovf_o <= ovf_c;
        end
    end
`else
    logic sat_unused;

    assign sat_unused = ^r_full[RW-1:O_WIDTH];
    assign result     = r_full[O_WIDTH-1:0];
    assign ovf_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mult_o  <= '0;
            valid_o <= 1'b0;
        end else if (en_i) begin
            mult_o  <= result;
            valid_o <= valid_d[PIPE_STAGES-1];
        end
    end

endmodule

// File: doc/mult_pipe_rnd.md
Name: mult_pipe_rnd

Overview:
Parametrised signed multiplier for the DDC datapath (mixer, filter coefficient products).
- Configurable post-multiply pipeline depth for DSP-slice timing closure.
- Valid tracking with a global stall.
- Runtime-selectable rounding: truncate, round-half-up or convergent.
- Output narrowed to O_WIDTH bits, with optional saturation and overflow flag.

Parameters:
A_WIDTH, 16, width of signed operand a_i
B_WIDTH, 16, width of signed operand b_i
O_WIDTH, 16, width of signed result mult_o; requires O_WIDTH + DROP_MSB <= A_WIDTH + B_WIDTH
DROP_MSB, 1, redundant sign MSBs discarded above the output window (0..A_WIDTH+B_WIDTH-O_WIDTH)
PIPE_STAGES, 3, register stages between product and rounding stage, >= 1

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
en_i  in  1  global clock enable; low freezes every pipeline register, including valid
valid_i  in  1  a_i/b_i/rnd_mode_i carry a sample
a_i  in  A_WIDTH  signed operand
b_i  in  B_WIDTH  signed operand
rnd_mode_i  in  2  0 truncate, 1 round-half-up, 2 convergent (half-to-even), 3 truncate
mult_o  out  O_WIDTH  signed rounded result
valid_o  out  1  mult_o/ovf_o hold a result
ovf_o  out  1  result saturated (per-sample, aligned with valid_o)

Behaviour:
- Widths: P = full signed product, N = A_WIDTH+B_WIDTH bits. D = N - DROP_MSB - O_WIDTH discarded LSBs. Kept window K = P[N-1-DROP_MSB : D], extended by one guard bit for the rounding add.
- Stage 1: register a_i, b_i, rnd_mode_i, valid_i.
- Stage 2: register P, mode, valid.
- Stages 3..PIPE_STAGES+2: delay line for P, mode and valid.
- Final stage: round, saturate/wrap, register into mult_o, ovf_o, valid_o.
- Latency: LAT = PIPE_STAGES + 3 enabled cycles from a sampled valid_i to valid_o. Throughput is one sample per enabled cycle.
- All stages advance only when en_i=1. With en_i=0, outputs hold, and valid_o holds its last value.
- Data stages load regardless of valid_i (no gating). valid_o=0 marks don't-care data, but mult_o still follows the pipeline.
- Truncate: R = floor(P / 2^D).
- Half-up: R = floor((P + 2^(D-1)) / 2^D).
- Convergent: as half-up, except when P[D-1:0] == 2^(D-1) exactly; then R = floor(P / 2^D) + K[0].
- D = 0: all modes are identical and no rounding add is performed.
- Negative values round toward +inf on a tie in half-up mode, toward even in convergent mode.
- Overflow: R outside [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1]. Causes: rounding carry, DROP_MSB bits not pure sign, or -max*-max.
- rnd_mode_i is sampled per sample with the operands. Mode changes mid-stream apply only to the new samples.
- Reset: every valid stage cleared, mult_o=0, ovf_o=0, valid_o=0, all data registers cleared. Takes effect regardless of en_i.
- Reset mid-operation: in-flight samples are discarded, and no valid_o appears for them after reset release. First new result arrives LAT enabled cycles after the first post-reset valid_i.
- rst_i and en_i both high: reset wins.

Optional Feature:
Macro MULT_PIPE_SAT_EN.
- Defined: on overflow, mult_o clamps to 2^(O_WIDTH-1)-1 (positive) or -2^(O_WIDTH-1) (negative), and ovf_o=1 for that sample.
- Undefined: mult_o = low O_WIDTH bits of R (two's-complement wrap), ovf_o is tied to 0, and the saturation logic is absent.

Test Plan:
Default params (LAT=6, D=15):
- a=0x4000, b=0x4000, mode 0, one valid -> exactly 6 enabled cycles later: valid_o=1 for one cycle, mult_o=0x2000, ovf_o=0.
- a=0x0001, b=0x4000 (tie at 0.5) -> mode0 0x0000, mode1 0x0001, mode2 0x0000.
- a=0x0003, b=0x4000 (1.5) -> mode0 0x0001, mode1 0x0002, mode2 0x0002.
- a=0xFFFF, b=0x4000 (-0.5) -> mode0 0xFFFF, mode1 0x0000, mode2 0x0000.
- a=0x8000, b=0x8000 -> with MULT_PIPE_SAT_EN: mult_o=0x7FFF, ovf_o=1; without: mult_o=0x8000, ovf_o=0.
- Stream 10 back-to-back samples; drop en_i for 3 cycles mid-stream; assert rst_i for 1 cycle while 4 samples are in flight:
  - Results appear in order, none lost or duplicated across the stall.
  - After reset, no valid_o for the flushed samples.
  - mult_o=0 and valid_o=0 on the cycle after reset.
